// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types for the three-port bus arbiter: requester bundle, grant encoding
// and arbiter state.
package bus_rr_arbiter_pkg;

  typedef struct packed {
    logic        rw;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } bus_req_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_A    = 2'd1,
    GRANT_B    = 2'd2,
    GRANT_C    = 2'd3
  } grant_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  function automatic logic [2:0] grant_onehot(input grant_t g);
    case (g)
      GRANT_A: return 3'b001;
      GRANT_B: return 3'b010;
      GRANT_C: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_pick.sv
// Combinational round-robin pick among three requesters, searching from the port
// after the most recently granted one (a -> b -> c -> a).
module bus_rr_arbiter_pick
  import bus_rr_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  grant_t     last,
  output logic       any,
  output grant_t     pick
);

  always_comb begin
    any  = |req;
    pick = GRANT_NONE;
    case (last)
      GRANT_A: begin
        if (req[1])      pick = GRANT_B;
        else if (req[2]) pick = GRANT_C;
        else if (req[0]) pick = GRANT_A;
      end
      GRANT_B: begin
        if (req[2])      pick = GRANT_C;
        else if (req[0]) pick = GRANT_A;
        else if (req[1]) pick = GRANT_B;
      end
      default: begin
        if (req[0])      pick = GRANT_A;
        else if (req[1]) pick = GRANT_B;
        else if (req[2]) pick = GRANT_C;
      end
    endcase
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one registered memory bus between three masters,
// with a saturating watchdog that aborts transactions the bus never completes.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int          TIMEOUT       = 1024,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic        i_clock,
  input  logic        i_reset,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  output logic [31:0] o_bus_wdata,
  input  logic [31:0] i_bus_rdata,
  output logic [3:0]  o_bus_wmask,
  input  logic        i_pa_rw,
  input  logic        i_pa_request,
  input  logic [31:0] i_pa_address,
  input  logic [31:0] i_pa_wdata,
  input  logic [3:0]  i_pa_wmask,
  output logic        o_pa_ready,
  output logic [31:0] o_pa_rdata,
  input  logic        i_pb_rw,
  input  logic        i_pb_request,
  input  logic [31:0] i_pb_address,
  input  logic [31:0] i_pb_wdata,
  input  logic [3:0]  i_pb_wmask,
  output logic        o_pb_ready,
  output logic [31:0] o_pb_rdata,
  input  logic        i_pc_rw,
  input  logic        i_pc_request,
  input  logic [31:0] i_pc_address,
  input  logic [31:0] i_pc_wdata,
  input  logic [3:0]  i_pc_wmask,
  output logic        o_pc_ready,
  output logic [31:0] o_pc_rdata,
  output logic        o_timeout,
  output logic [1:0]  o_grant
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  arb_state_t      state, state_next;
  grant_t          owner, last, pick;
  logic            any_req, owner_req, wd_expire, done;
  logic [2:0]      req_vec, pick_oh, owner_oh, ready_q;
  bus_req_t        req [3];
  bus_req_t        bus_q;
  logic [WD_W-1:0] wd_count;
  logic [31:0]     rdata_q [3];
  logic            timeout_q;

  // Holds at the terminal count instead of wrapping.
  function automatic logic [WD_W-1:0] wd_sat_inc(input logic [WD_W-1:0] c);
    return (c == WD_LAST) ? c : c + WD_W'(1);
  endfunction

  assign req_vec = {i_pc_request, i_pb_request, i_pa_request};
  assign req[0]  = '{rw: i_pa_rw, address: i_pa_address, wdata: i_pa_wdata, wmask: i_pa_wmask};
  assign req[1]  = '{rw: i_pb_rw, address: i_pb_address, wdata: i_pb_wdata, wmask: i_pb_wmask};
  assign req[2]  = '{rw: i_pc_rw, address: i_pc_address, wdata: i_pc_wdata, wmask: i_pc_wmask};

  bus_rr_arbiter_pick u_pick (
    .req  (req_vec),
    .last (last),
    .any  (any_req),
    .pick (pick)
  );

  assign pick_oh   = grant_onehot(pick);
  assign owner_oh  = grant_onehot(owner);
  assign owner_req = |(req_vec & owner_oh);
  assign wd_expire = (TIMEOUT != 0) && (wd_count == WD_LAST);
  assign done      = i_bus_ready || wd_expire;

  always_ff @(posedge i_clock) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (any_req)    state_next = ST_BUSY;
      ST_BUSY:    if (done)       state_next = ST_RELEASE;
      ST_RELEASE: if (!owner_req) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_bus_request = (state == ST_BUSY);
    o_grant       = (state == ST_IDLE) ? GRANT_NONE : owner;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      owner     <= GRANT_NONE;
      last      <= GRANT_C;
      bus_q     <= '0;
      wd_count  <= '0;
      ready_q   <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
    end else begin
      ready_q <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            for (int i = 0; i < 3; i++) if (pick_oh[i]) bus_q <= req[i];
            owner    <= pick;
            last     <= pick;
            wd_count <= '0;
          end
        end
        ST_BUSY: begin
          // A real completion takes precedence over a watchdog expiry in the same cycle.
          if (done) begin
            ready_q <= owner_oh;
            for (int i = 0; i < 3; i++)
              if (owner_oh[i]) rdata_q[i] <= i_bus_ready ? i_bus_rdata : TIMEOUT_RDATA;
            if (!i_bus_ready) timeout_q <= 1'b1;
          end else begin
            wd_count <= wd_sat_inc(wd_count);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_bus_rw      = bus_q.rw;
  assign o_bus_address = bus_q.address;
  assign o_bus_wdata   = bus_q.wdata;
  assign o_bus_wmask   = bus_q.wmask;
  assign o_pa_ready    = ready_q[0];
  assign o_pb_ready    = ready_q[1];
  assign o_pc_ready    = ready_q[2];
  assign o_pa_rdata    = rdata_q[0];
  assign o_pb_rdata    = rdata_q[1];
  assign o_pc_rdata    = rdata_q[2];
  assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: a bus model with programmable latency, per-port
// expected read data queues, and directed sequences for rotation, stickiness and timeout.
module tb_bus_rr_arbiter;

  localparam int TO = 8;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b0;
  logic        o_bus_rw, o_bus_request;
  logic        i_bus_ready = 1'b0;
  logic [31:0] o_bus_address, o_bus_wdata;
  logic [31:0] i_bus_rdata = '0;
  logic [3:0]  o_bus_wmask;
  logic        i_pa_rw = 1'b0, i_pa_request = 1'b0;
  logic [31:0] i_pa_address = '0, i_pa_wdata = '0;
  logic [3:0]  i_pa_wmask = '0;
  logic        o_pa_ready;
  logic [31:0] o_pa_rdata;
  logic        i_pb_rw = 1'b0, i_pb_request = 1'b0;
  logic [31:0] i_pb_address = '0, i_pb_wdata = '0;
  logic [3:0]  i_pb_wmask = '0;
  logic        o_pb_ready;
  logic [31:0] o_pb_rdata;
  logic        i_pc_rw = 1'b0, i_pc_request = 1'b0;
  logic [31:0] i_pc_address = '0, i_pc_wdata = '0;
  logic [3:0]  i_pc_wmask = '0;
  logic        o_pc_ready;
  logic [31:0] o_pc_rdata;
  logic        o_timeout;
  logic [1:0]  o_grant;

  bus_rr_arbiter #(.TIMEOUT(TO), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request), .i_bus_ready(i_bus_ready),
    .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata), .i_bus_rdata(i_bus_rdata),
    .o_bus_wmask(o_bus_wmask),
    .i_pa_rw(i_pa_rw), .i_pa_request(i_pa_request), .i_pa_address(i_pa_address),
    .i_pa_wdata(i_pa_wdata), .i_pa_wmask(i_pa_wmask), .o_pa_ready(o_pa_ready), .o_pa_rdata(o_pa_rdata),
    .i_pb_rw(i_pb_rw), .i_pb_request(i_pb_request), .i_pb_address(i_pb_address),
    .i_pb_wdata(i_pb_wdata), .i_pb_wmask(i_pb_wmask), .o_pb_ready(o_pb_ready), .o_pb_rdata(o_pb_rdata),
    .i_pc_rw(i_pc_rw), .i_pc_request(i_pc_request), .i_pc_address(i_pc_address),
    .i_pc_wdata(i_pc_wdata), .i_pc_wmask(i_pc_wmask), .o_pc_ready(o_pc_ready), .o_pc_rdata(o_pc_rdata),
    .o_timeout(o_timeout), .o_grant(o_grant)
  );

  always #5 i_clock = ~i_clock;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus model data: address plus a fixed offset, so 0x1000 reads back 0x12345678.
  function automatic logic [31:0] bus_fn(input logic [31:0] a);
    return a + 32'h1234_4678;
  endfunction

  int          bus_lat = 1;
  int          bus_cnt = 0;
  bit          bus_done = 1'b0;
  bit          bus_unstable = 1'b0;
  logic        seen_rw = 1'b0;
  logic [31:0] seen_addr = '0, seen_wdata = '0;
  logic [3:0]  seen_wmask = '0;

  // bus_lat is the 0-based request cycle in which ready is returned; negative means never
  always @(negedge i_clock) begin
    i_bus_ready = 1'b0;
    i_bus_rdata = $urandom;
    if (o_bus_request && !bus_done) begin
      if (bus_cnt == 0) begin
        seen_rw = o_bus_rw; seen_addr = o_bus_address;
        seen_wdata = o_bus_wdata; seen_wmask = o_bus_wmask;
      end else if (o_bus_rw !== seen_rw || o_bus_address !== seen_addr ||
                   o_bus_wdata !== seen_wdata || o_bus_wmask !== seen_wmask) begin
        bus_unstable = 1'b1;
      end
      if (bus_cnt == bus_lat) begin
        i_bus_ready = 1'b1;
        i_bus_rdata = bus_fn(o_bus_address);
        bus_done = 1'b1;
      end
      bus_cnt++;
    end else if (!o_bus_request) begin
      bus_cnt = 0;
      bus_done = 1'b0;
    end
  end

  logic [31:0] sb_q0[$], sb_q1[$], sb_q2[$];
  logic [1:0]  grant_log[$];
  logic [1:0]  prev_grant = 2'd0;
  int          rdy_cnt[3] = '{0, 0, 0};

  task automatic sb_push(input int p, input logic [31:0] v);
    case (p)
      0: sb_q0.push_back(v);
      1: sb_q1.push_back(v);
      default: sb_q2.push_back(v);
    endcase
  endtask

  task automatic sb_pop_chk(input int p, input logic [31:0] got);
    logic [31:0] e;
    case (p)
      0: if (sb_q0.size() == 0) chk("sb_empty_a", 32'(sb_q0.size()), 1);
         else begin e = sb_q0.pop_front(); chk("rdata_a", got, e); end
      1: if (sb_q1.size() == 0) chk("sb_empty_b", 32'(sb_q1.size()), 1);
         else begin e = sb_q1.pop_front(); chk("rdata_b", got, e); end
      default: if (sb_q2.size() == 0) chk("sb_empty_c", 32'(sb_q2.size()), 1);
         else begin e = sb_q2.pop_front(); chk("rdata_c", got, e); end
    endcase
  endtask

  always @(negedge i_clock) begin
    if (i_reset) begin
      if (o_pa_ready) begin rdy_cnt[0]++; sb_pop_chk(0, o_pa_rdata); end
      if (o_pb_ready) begin rdy_cnt[1]++; sb_pop_chk(1, o_pb_rdata); end
      if (o_pc_ready) begin rdy_cnt[2]++; sb_pop_chk(2, o_pc_rdata); end
      if (o_grant != 2'd0 && prev_grant == 2'd0) grant_log.push_back(o_grant);
    end
    prev_grant = o_grant;
  end

  task automatic set_port(input int p, input logic rq, input logic rw, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] wm);
    case (p)
      0: begin i_pa_request = rq; i_pa_rw = rw; i_pa_address = a; i_pa_wdata = wd; i_pa_wmask = wm; end
      1: begin i_pb_request = rq; i_pb_rw = rw; i_pb_address = a; i_pb_wdata = wd; i_pb_wmask = wm; end
      default: begin i_pc_request = rq; i_pc_rw = rw; i_pc_address = a; i_pc_wdata = wd; i_pc_wmask = wm; end
    endcase
  endtask

  function automatic logic ready_of(input int p);
    case (p)
      0: return o_pa_ready;
      1: return o_pb_ready;
      default: return o_pc_ready;
    endcase
  endfunction

  // Called on a falling edge; lat = falling edges from raising request to seeing ready.
  task automatic txn(input int p, input logic rw, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] wm, output int lat);
    int n;
    sb_push(p, (bus_lat < 0) ? 32'hDEAD_BEEF : bus_fn(a));
    set_port(p, 1'b1, rw, a, wd, wm);
    n = 0;
    do begin
      @(negedge i_clock);
      n++;
    end while (!ready_of(p) && n < 200);
    if (n >= 200) chk("txn_wait", 32'(ready_of(p)), 1);
    lat = n;
    set_port(p, 1'b0, rw, a, wd, wm);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    @(negedge i_clock);
  endtask

  int lat, lat_b, n;
  int base[3];
  logic [1:0] g;
  logic [1:0] exp_rot[6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};

  initial begin
    repeat (3) @(negedge i_clock);
    chk("rst_bus_request", 32'(o_bus_request), 0);
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_bus_ctl", {27'd0, o_bus_rw, o_bus_wmask}, 0);
    chk("rst_bus_address", o_bus_address, 0);
    chk("rst_bus_wdata", o_bus_wdata, 0);
    chk("rst_ready", {29'd0, o_pa_ready, o_pb_ready, o_pc_ready}, 0);
    chk("rst_rdata", o_pa_rdata | o_pb_rdata | o_pc_rdata, 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    i_reset = 1'b1;
    @(negedge i_clock);

    // single read from port b, bus answers in its third request cycle
    bus_lat = 2;
    base = rdy_cnt;
    txn(1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, lat);
    chk("rd_latency", 32'(lat), 4);
    repeat (3) @(negedge i_clock);
    chk("rd_pb_rdata", o_pb_rdata, 32'h1234_5678);
    chk("rd_pb_pulses", 32'(rdy_cnt[1] - base[1]), 1);
    chk("rd_pa_pulses", 32'(rdy_cnt[0] - base[0]), 0);
    chk("rd_pc_pulses", 32'(rdy_cnt[2] - base[2]), 0);

    // write forwarding from port c, held over several bus cycles
    bus_lat = 3;
    bus_unstable = 1'b0;
    txn(2, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'b0011, lat);
    chk("wr_bus_rw", 32'(seen_rw), 1);
    chk("wr_bus_address", seen_addr, 32'h20);
    chk("wr_bus_wdata", seen_wdata, 32'hCAFE_F00D);
    chk("wr_bus_wmask", 32'(seen_wmask), 32'b0011);
    chk("wr_bus_stable", 32'(bus_unstable), 0);
    @(negedge i_clock);

    // contention rotation from reset
    do_reset();
    bus_lat = 1;
    grant_log.delete();
    fork
      for (int k = 0; k < 2; k++) begin int l0; txn(0, 1'b0, 32'h100 + 32'(k), 32'h0, 4'h0, l0); @(negedge i_clock); end
      for (int k = 0; k < 2; k++) begin int l1; txn(1, 1'b0, 32'h200 + 32'(k), 32'h0, 4'h0, l1); @(negedge i_clock); end
      for (int k = 0; k < 2; k++) begin int l2; txn(2, 1'b0, 32'h300 + 32'(k), 32'h0, 4'h0, l2); @(negedge i_clock); end
    join
    chk("rot_count", 32'(grant_log.size()), 6);
    for (int i = 0; i < 6; i++) begin
      g = (i < grant_log.size()) ? grant_log[i] : 2'd0;
      chk($sformatf("rot_%0d", i), 32'(g), 32'(exp_rot[i]));
    end

    // sticky request on a while b waits
    bus_lat = 2;
    sb_push(0, bus_fn(32'h500));
    set_port(0, 1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
    @(negedge i_clock);
    fork
      txn(1, 1'b0, 32'h600, 32'h0, 4'h0, lat_b);
      begin
        n = 0;
        while (!o_pa_ready && n < 50) begin @(negedge i_clock); n++; end
        if (n >= 50) chk("sticky_wait", 32'(o_pa_ready), 1);
        for (int i = 0; i < 5; i++) begin
          @(negedge i_clock);
          chk("sticky_grant", 32'(o_grant), 1);
          chk("sticky_bus_request", 32'(o_bus_request), 0);
        end
        set_port(0, 1'b0, 1'b0, 32'h500, 32'h0, 4'h0);
        @(negedge i_clock);
        chk("sticky_gap", 32'(o_grant), 0);
        @(negedge i_clock);
        chk("sticky_b_grant", 32'(o_grant), 2);
      end
    join
    @(negedge i_clock);

    // watchdog abort: bus never answers
    bus_lat = -1;
    txn(2, 1'b0, 32'h700, 32'h0, 4'h0, lat);
    chk("to_latency", 32'(lat), 9);
    chk("to_rdata", o_pc_rdata, 32'hDEAD_BEEF);
    chk("to_flag", 32'(o_timeout), 1);
    @(negedge i_clock);
    bus_lat = 1;
    txn(0, 1'b0, 32'h710, 32'h0, 4'h0, lat);
    chk("to_flag_sticky", 32'(o_timeout), 1);
    @(negedge i_clock);

    // reset during BUSY
    bus_lat = -1;
    set_port(0, 1'b1, 1'b0, 32'h800, 32'h0, 4'h0);
    repeat (3) @(negedge i_clock);
    chk("mid_busy", 32'(o_bus_request), 1);
    i_reset = 1'b0;
    @(negedge i_clock);
    chk("mid_bus_request", 32'(o_bus_request), 0);
    chk("mid_grant", 32'(o_grant), 0);
    chk("mid_bus_address", o_bus_address, 0);
    chk("mid_pa_rdata", o_pa_rdata, 0);
    chk("mid_timeout", 32'(o_timeout), 0);
    set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    i_reset = 1'b1;
    bus_lat = 1;
    @(negedge i_clock);
    txn(0, 1'b0, 32'h900, 32'h0, 4'h0, lat);
    chk("mid_fresh_latency", 32'(lat), 3);
    repeat (3) @(negedge i_clock);

    chk("sb_left", 32'(sb_q0.size() + sb_q1.size() + sb_q2.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish, required finish within 300000 time units");
    $fatal(1, "simulation bound expired");
  end

endmodule
